// File: rtl/boot_copy_pkg.sv
// Shared types and constants for the boot copy engine.
// Contents:
//   boot_state_e - sequencer states
//   WORD_BYTES   - byte stride between image words
//   IDX_W/HOLD_W - widths of the word index and hold timer
package boot_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    HOLD,
    DONE
  } boot_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IDX_W      = 16;
  localparam int unsigned HOLD_W     = 16;

endpackage

// File: rtl/boot_copy_edge_det.sv
// Rising-edge detector for a level that is already synchronous to clk.
// Ports:
//   clk, reset_n - clock, async active-low reset
//   din          - level input
//   rise         - one-cycle pulse when din is high and was low last cycle
module boot_copy_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  // Because din_q resets low, a level already high at reset release fires
  // on the first clock after release.
  assign rise = din && !din_q;

endmodule

// File: rtl/boot_copy_engine.sv
// Copies a fixed-size boot image from source to destination memory over two
// Avalon-MM masters, holding the target processor in reset during the copy
// and for a settle window afterwards.
// Ports:
//   clk, reset_n                     - clock, async active-low reset
//   start                            - boot request level (rising edge triggers)
//   rd_address/rd_read/rd_readdata/rd_waitrequest  - read master
//   wr_address/wr_write/wr_writedata/wr_waitrequest - write master
//   tgt_reset_n                      - active-low reset to the target processor
//   busy, done, words_done           - status
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | never run since reset, target held
// READ  | read strobe up for word idx, waiting out rd_waitrequest
// WRITE | write strobe up for word idx, waiting out wr_waitrequest
// HOLD  | image written, target still held while hold timer runs down
// DONE  | target released, waiting for next trigger
module boot_copy_engine
  import boot_copy_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  SRC_BASE    = '0,
  parameter logic [ADDR_W-1:0]  DST_BASE    = ADDR_W'(32'h0001_0000),
  parameter int unsigned        WORDS       = 256,
  parameter int unsigned        HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_read,
  input  logic [31:0]       rd_readdata,
  input  logic              rd_waitrequest,
  output logic [ADDR_W-1:0] wr_address,
  output logic              wr_write,
  output logic [31:0]       wr_writedata,
  input  logic              wr_waitrequest,
  output logic              tgt_reset_n,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_done
);

  // LAST_IDX is meaningless when WORDS==0, but that case never enters WRITE.
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic              trigger;
  boot_state_e       state;
  logic [IDX_W-1:0]  idx;
  logic [HOLD_W-1:0] hold_cnt;

  // Byte address of word i; wraps silently modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  i);
    return base + (ADDR_W'(i) * ADDR_W'(WORD_BYTES));
  endfunction

  boot_copy_edge_det u_start_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (start),
    .rise   (trigger)
  );

  // Strobes and addresses are loaded on the transition into READ/WRITE so
  // every bus output comes straight from a flop and stays put during stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      hold_cnt     <= '0;
      rd_read      <= 1'b0;
      rd_address   <= '0;
      wr_write     <= 1'b0;
      wr_address   <= '0;
      wr_writedata <= '0;
      tgt_reset_n  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_done   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (trigger) begin
            idx         <= '0;
            words_done  <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            tgt_reset_n <= 1'b0;
            if (WORDS == 0) begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end else begin
              rd_read    <= 1'b1;
              rd_address <= word_addr(SRC_BASE, '0);
              state      <= READ;
            end
          end
        end
        READ: begin
          if (!rd_waitrequest) begin
            wr_writedata <= rd_readdata;
            rd_read      <= 1'b0;
            wr_write     <= 1'b1;
            wr_address   <= word_addr(DST_BASE, idx);
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (!wr_waitrequest) begin
            words_done <= words_done + 16'd1;
            wr_write   <= 1'b0;
            if (idx == LAST_IDX) begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end else begin
              idx        <= idx + 16'd1;
              rd_read    <= 1'b1;
              rd_address <= word_addr(SRC_BASE, idx + 16'd1);
              state      <= READ;
            end
          end
        end
        HOLD: begin
          // Loaded with HOLD_CYCLES-1 so release lands exactly HOLD_CYCLES
          // cycles after the final write handshake.
          if (hold_cnt == '0) begin
            tgt_reset_n <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_copy_engine.sv
// Self-checking bench for boot_copy_engine: a memory responder with random
// stalls, expected reads/writes/completions queued at trigger time, and a
// monitor that pops and compares on every bus handshake.
module tb_boot_copy_engine;

  localparam int          W    = 4;
  localparam int          H    = 3;
  localparam int          H0   = 5;
  localparam logic [31:0] SRC  = 32'h0000_0000;
  localparam logic [31:0] DST  = 32'h0001_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;

  logic [31:0] rd_address, wr_address, wr_writedata;
  logic        rd_read, wr_write, tgt_reset_n, busy, done;
  logic [15:0] words_done;
  logic [31:0] rd_readdata = '0;
  logic        rd_waitrequest = 1'b0;
  logic        wr_waitrequest = 1'b0;

  logic [31:0] rd_address0, wr_address0, wr_writedata0;
  logic        rd_read0, wr_write0, tgt_reset_n0, busy0, done0;
  logic [15:0] words_done0;

  always #5 clk = ~clk;

  boot_copy_engine #(
    .ADDR_W(32), .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(W), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rd_address(rd_address), .rd_read(rd_read), .rd_readdata(rd_readdata),
    .rd_waitrequest(rd_waitrequest),
    .wr_address(wr_address), .wr_write(wr_write), .wr_writedata(wr_writedata),
    .wr_waitrequest(wr_waitrequest),
    .tgt_reset_n(tgt_reset_n), .busy(busy), .done(done), .words_done(words_done)
  );

  boot_copy_engine #(
    .ADDR_W(32), .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(0), .HOLD_CYCLES(H0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .rd_address(rd_address0), .rd_read(rd_read0), .rd_readdata(32'h0),
    .rd_waitrequest(1'b0),
    .wr_address(wr_address0), .wr_write(wr_write0), .wr_writedata(wr_writedata0),
    .wr_waitrequest(1'b0),
    .tgt_reset_n(tgt_reset_n0), .busy(busy0), .done(done0), .words_done(words_done0)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] src_mem [W];
  logic [31:0] dst_mem [W];
  logic [31:0] rd_q [$];
  logic [63:0] wr_q [$];
  int          done_q [$];

  bit stall_en = 1'b0;
  bit rd_act = 1'b0, wr_act = 1'b0;
  int rd_stall = 0, wr_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [31:0] a);
    logic [31:0] off;
    off = (a - SRC) >> 2;
    if (off < W) return src_mem[off[1:0]];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: each new strobe gets 0..5 stall cycles when enabled.
  always @(posedge clk) begin
    #1;
    if (rd_read) begin
      if (!rd_act) begin
        rd_act   = 1'b1;
        rd_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
      end else if (rd_stall > 0) rd_stall--;
    end else rd_act = 1'b0;
    if (wr_write) begin
      if (!wr_act) begin
        wr_act   = 1'b1;
        wr_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
      end else if (wr_stall > 0) wr_stall--;
    end else wr_act = 1'b0;
    rd_waitrequest = rd_read && (rd_stall > 0);
    wr_waitrequest = wr_write && (wr_stall > 0);
    rd_readdata    = rd_waitrequest ? $urandom : src_word(rd_address);
  end

  // Monitor
  bit          prev_rd_stall = 1'b0, prev_wr_stall = 1'b0;
  logic [31:0] prev_rd_addr, prev_wr_addr, prev_wr_data;
  bit          done_prev = 1'b0, busy_prev = 1'b0;
  int          busy_len = 0;
  int          wr_hs_cyc = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rd_stall = 1'b0;
      prev_wr_stall = 1'b0;
      done_prev     = 1'b0;
      busy_prev     = 1'b0;
    end else begin
      if (rd_read || wr_write) chk("strobe_overlap", 64'(rd_read && wr_write), 64'd0);
      if (prev_rd_stall) begin
        chk("rd_stall_strobe", 64'(rd_read), 64'd1);
        chk("rd_stall_addr", 64'(rd_address), 64'(prev_rd_addr));
      end
      if (prev_wr_stall) begin
        chk("wr_stall_strobe", 64'(wr_write), 64'd1);
        chk("wr_stall_addr", 64'(wr_address), 64'(prev_wr_addr));
        chk("wr_stall_data", 64'(wr_writedata), 64'(prev_wr_data));
      end
      prev_rd_stall = rd_read && rd_waitrequest;
      prev_wr_stall = wr_write && wr_waitrequest;
      prev_rd_addr  = rd_address;
      prev_wr_addr  = wr_address;
      prev_wr_data  = wr_writedata;

      if (rd_read && !rd_waitrequest) begin
        if (rd_q.size() == 0) chk("unexpected_read", 64'(rd_address), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("rd_addr", 64'(rd_address), 64'(rd_q.pop_front()));
      end
      if (wr_write && !wr_waitrequest) begin
        if (wr_q.size() == 0) chk("unexpected_write", 64'(wr_address), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          logic [63:0] e;
          e = wr_q.pop_front();
          chk("wr_addr", 64'(wr_address), 64'(e[63:32]));
          chk("wr_data", 64'(wr_writedata), 64'(e[31:0]));
          if (((wr_address - DST) >> 2) < W) dst_mem[2'((wr_address - DST) >> 2)] = wr_writedata;
        end
        wr_hs_cyc = cyc + 1;
      end

      if (busy && !busy_prev) busy_len = 1;
      else if (busy) busy_len++;

      if (done && !done_prev) begin
        if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          int eb;
          eb = done_q.pop_front();
          chk("done_words", 64'(words_done), 64'(W));
          chk("done_tgt_released", 64'(tgt_reset_n), 64'd1);
          chk("done_busy_low", 64'(busy), 64'd0);
          chk("hold_after_last_write", 64'(cyc - wr_hs_cyc), 64'(H));
          if (eb >= 0) chk("busy_length", 64'(busy_len), 64'(eb));
        end
      end
      done_prev = done;
      busy_prev = busy;
    end
  end

  task automatic wait_run_end();
    for (int k = 0; k < 3000 && done_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("run_timeout", 64'(done_q.size()), 64'd0);
  endtask

  task automatic queue_run(input int exp_busy);
    for (int i = 0; i < W; i++) begin
      rd_q.push_back(SRC + 32'(4 * i));
      wr_q.push_back({DST + 32'(4 * i), src_mem[i]});
      dst_mem[i] = 32'hBAD0_0000 | 32'(i);
    end
    done_q.push_back(exp_busy);
  endtask

  task automatic do_run(input int exp_busy, input bit hold_start, input bit extra_pulse);
    for (int i = 0; i < W; i++) src_mem[i] = $urandom;
    queue_run(exp_busy);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    #1;
    chk("trig_tgt_low", 64'(tgt_reset_n), 64'd0);
    chk("trig_done_low", 64'(done), 64'd0);
    chk("trig_busy", 64'(busy), 64'd1);
    if (hold_start) repeat (19) @(negedge clk);
    start = 1'b0;
    if (extra_pulse) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_run_end();
    repeat (6) @(negedge clk);
    #1;
    chk("idle_after_run", 64'(busy), 64'd0);
    chk("words_done_final", 64'(words_done), 64'(W));
    for (int i = 0; i < W; i++) chk("dst_image", 64'(dst_mem[i]), 64'(src_mem[i]));
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int k;
    bit strobe_seen;
    for (int i = 0; i < W; i++) src_mem[i] = $urandom;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tgt", 64'(tgt_reset_n), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_words", 64'(words_done), 64'd0);
    chk("rst_strobes", 64'({rd_read, wr_write}), 64'd0);
    chk("rst0_tgt", 64'(tgt_reset_n0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero wait states: 2 cycles per word plus the hold window.
    stall_en = 1'b0;
    do_run(2 * W + H, 1'b0, 1'b0);

    // Random stalls, with an ignored mid-copy pulse.
    stall_en = 1'b1;
    for (int r = 0; r < 3; r++) do_run(-1, 1'b0, 1'b1);

    // Start held high for 20 cycles: one run only.
    stall_en = 1'b0;
    do_run(2 * W + H, 1'b1, 1'b0);

    // Zero-word image: straight to hold, released HOLD_CYCLES cycles
    // after the trigger edge.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    #1;
    chk("w0_busy", 64'(busy0), 64'd1);
    chk("w0_tgt_low", 64'(tgt_reset_n0), 64'd0);
    k = 1;
    found = 1'b0;
    strobe_seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (rd_read0 || wr_write0) strobe_seen = 1'b1;
      if (done0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      k++;
    end
    chk("w0_done_seen", 64'(found), 64'd1);
    chk("w0_done_latency", 64'(k), 64'(H0 + 1));
    chk("w0_no_strobes", 64'(strobe_seen), 64'd0);
    chk("w0_tgt_released", 64'(tgt_reset_n0), 64'd1);
    chk("w0_busy_low", 64'(busy0), 64'd0);

    // Reset during the second write.
    stall_en = 1'b0;
    for (int i = 0; i < W; i++) src_mem[i] = $urandom;
    queue_run(-1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      #1;
      if (wr_write && wr_address == DST + 32'd4) begin
        found = 1'b1;
        break;
      end
    end
    chk("second_write_seen", 64'(found), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_read", 64'(rd_read), 64'd0);
    chk("mid_rst_wr_write", 64'(wr_write), 64'd0);
    chk("mid_rst_rd_addr", 64'(rd_address), 64'd0);
    chk("mid_rst_wr_addr", 64'(wr_address), 64'd0);
    chk("mid_rst_wr_data", 64'(wr_writedata), 64'd0);
    chk("mid_rst_tgt", 64'(tgt_reset_n), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_words", 64'(words_done), 64'd0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    do_run(2 * W + H, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
